// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU read/write, DMA read-only) arbiter in front of
// a single-port combinational-read data memory. One transaction takes three
// cycles: IDLE (arbitrate and latch), SERVE (drive memory, capture read data),
// and ACK (one-cycle completion pulse to the winner).
// The CPU has priority. After STARVE_MAX consecutive contested CPU wins, the
// DMA is forced a grant.
// Optional feature: define MEM_ARB_STATS_EN to build the saturating grant
// counters. When it is undefined, cpu_grants and dma_grants read as zero.
module mem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [15:0]   cpu_grants,
  output logic [15:0]   dma_grants
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_CPU = 2'd1,
    SERVE_DMA = 2'd2,
    ACK       = 2'd3
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_starve;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_sel_dma;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          w_grant_cpu;
  logic          w_grant_dma;
  logic          w_starved;

  assign w_starved = (r_starve == LP_STARVE_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and arbitration; a starved DMA overrides CPU priority
  always_comb begin
    w_next      = r_state;
    w_grant_cpu = 1'b0;
    w_grant_dma = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req && !(dma_req && w_starved)) begin
          w_grant_cpu = 1'b1;
          w_next      = SERVE_CPU;
        end else if (dma_req) begin
          w_grant_dma = 1'b1;
          w_next      = SERVE_DMA;
        end
      end
      SERVE_CPU: w_next = ACK;
      SERVE_DMA: w_next = ACK;
      ACK:       w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Latch winner's request so later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_sel_dma <= 1'b0;
    end else if (w_grant_cpu) begin
      r_addr    <= cpu_addr;
      r_wdata   <= cpu_wdata;
      r_we      <= cpu_we;
      r_sel_dma <= 1'b0;
    end else if (w_grant_dma) begin
      r_addr    <= dma_addr;
      r_we      <= 1'b0;
      r_sel_dma <= 1'b1;
    end
  end

  // Starve counter: counts contested CPU wins, cleared when DMA is idle or served
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (!dma_req || w_grant_dma) r_starve <= '0;
      else if (w_grant_cpu)        r_starve <= r_starve + 4'd1;
    end
  end

  // Capture memory read data into the serving requester's register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else if (r_state == SERVE_CPU) begin
      r_cpu_rdata <= mem_rdata;
    end else if (r_state == SERVE_DMA) begin
      r_dma_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_cpu_grants;
  logic [15:0] r_dma_grants;

  // Saturating grant counters, bumped on each entry to a SERVE state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_grants <= '0;
      r_dma_grants <= '0;
    end else begin
      if (w_grant_cpu && (r_cpu_grants != '1)) r_cpu_grants <= r_cpu_grants + 16'd1;
      if (w_grant_dma && (r_dma_grants != '1)) r_dma_grants <= r_dma_grants + 16'd1;
    end
  end

  assign cpu_grants = r_cpu_grants;
  assign dma_grants = r_dma_grants;
`else
  assign cpu_grants = '0;
  assign dma_grants = '0;
`endif

  // Reset gates mem_we combinationally so that an interrupted write never lands
  assign mem_we    = (r_state == SERVE_CPU) && r_we && !reset;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_ack   = (r_state == ACK) && !r_sel_dma;
  assign dma_ack   = (r_state == ACK) &&  r_sel_dma;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, with a behavioural word memory on the
// memory port. Build with MEM_ARB_STATS_EN defined to exercise the grant counters.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_we, busy;
  logic [15:0] cpu_grants, dma_grants;

  logic [31:0] mem [0:255];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_arbiter #(.DW(32), .AW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .cpu_grants(cpu_grants), .dma_grants(dma_grants)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain CPU read from IDLE through to the following IDLE
  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    step();
    step();
    chk("cpu_read_ack", {31'd0, cpu_ack}, 32'd1);
    chk("cpu_read_data", cpu_rdata, exp);
    cpu_req = 1'b0;
    step();
  endtask

  // Plain DMA read from IDLE through to the following IDLE
  task automatic dma_read(input logic [31:0] a, input logic [31:0] exp);
    dma_req = 1'b1; dma_addr = a;
    step();
    step();
    chk("dma_read_ack", {31'd0, dma_ack}, 32'd1);
    chk("dma_read_data", dma_rdata, exp);
    dma_req = 1'b0;
    step();
  endtask

  logic [9:0] exp_dma_order;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h08] = 32'h12345678;   // byte address 0x20
    mem[8'h0C] = 32'h11111111;   // byte address 0x30
    mem[8'h11] = 32'h44444444;   // byte address 0x44
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0;

    // Reset state
    step(); step();
    chk("rst_busy",      {31'd0, busy},    32'd0);
    chk("rst_cpu_ack",   {31'd0, cpu_ack}, 32'd0);
    chk("rst_dma_ack",   {31'd0, dma_ack}, 32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},  32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_cpu_gr",    {16'd0, cpu_grants}, 32'd0);
    chk("rst_dma_gr",    {16'd0, dma_grants}, 32'd0);
    reset = 1'b0;
    step();

    // CPU write 0x10 <= DEADBEEF
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1 chk("wr_idle_we", {31'd0, mem_we}, 32'd0);
    step();
    chk("wr_serve_we",    {31'd0, mem_we}, 32'd1);
    chk("wr_serve_addr",  mem_addr,  32'h10);
    chk("wr_serve_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_serve_busy",  {31'd0, busy}, 32'd1);
    chk("wr_serve_ack",   {31'd0, cpu_ack}, 32'd0);
    step();
    chk("wr_ack",         {31'd0, cpu_ack}, 32'd1);
    chk("wr_ack_we",      {31'd0, mem_we}, 32'd0);
    chk("wr_ack_dma",     {31'd0, dma_ack}, 32'd0);
    chk("wr_ack_addr",    mem_addr, 32'h10);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("wr_done_ack",    {31'd0, cpu_ack}, 32'd0);
    chk("wr_done_busy",   {31'd0, busy}, 32'd0);
    chk("wr_mem",         mem[8'h04], 32'hDEADBEEF);

    // CPU read back 0x10
    cpu_req = 1'b1; cpu_addr = 32'h10;
    step();
    chk("rd_serve_we",  {31'd0, mem_we}, 32'd0);
    chk("rd_serve_ack", {31'd0, cpu_ack}, 32'd0);
    step();
    chk("rd_ack",       {31'd0, cpu_ack}, 32'd1);
    chk("rd_data",      cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step();

    // DMA read 0x20
    dma_req = 1'b1; dma_addr = 32'h20;
    step();
    chk("dma_serve_we",   {31'd0, mem_we}, 32'd0);
    chk("dma_serve_addr", mem_addr, 32'h20);
    chk("dma_serve_ack",  {31'd0, dma_ack}, 32'd0);
    step();
    chk("dma_ack",        {31'd0, dma_ack}, 32'd1);
    chk("dma_ack_cpu",    {31'd0, cpu_ack}, 32'd0);
    chk("dma_ack_we",     {31'd0, mem_we}, 32'd0);
    chk("dma_data",       dma_rdata, 32'h12345678);
    dma_req = 1'b0;
    step();

    // Both requesting continuously: expect C,C,C,C,D,C,C,C,C,D
    exp_dma_order = 10'b1000010000;   // bit k set means transaction k goes to DMA
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      step();
      step();
      chk($sformatf("starve_cpu_ack%0d", k), {31'd0, cpu_ack}, {31'd0, ~exp_dma_order[k]});
      chk($sformatf("starve_dma_ack%0d", k), {31'd0, dma_ack}, {31'd0,  exp_dma_order[k]});
      step();
      chk($sformatf("starve_idle%0d", k), {31'd0, busy}, 32'd0);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step();
    chk("starve_quiet", {31'd0, busy}, 32'd0);

    // Reset asserted during the SERVE_CPU cycle of a write to 0x30
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
    step();
    chk("rstw_serve_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1 chk("rstw_we_gated", {31'd0, mem_we}, 32'd0);
    step();
    chk("rstw_busy",  {31'd0, busy}, 32'd0);
    chk("rstw_ack",   {31'd0, cpu_ack}, 32'd0);
    chk("rstw_mem",   mem[8'h0C], 32'h11111111);
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("rstw_ack2",  {31'd0, cpu_ack}, 32'd0);
    chk("rstw_rdata", cpu_rdata, 32'd0);

    // Inputs changed after latching do not affect the transaction
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    step();
    cpu_addr = 32'h44; cpu_we = 1'b1; cpu_wdata = 32'hBAD0BAD0;
    #1;
    chk("chg_addr", mem_addr, 32'h10);
    chk("chg_we",   {31'd0, mem_we}, 32'd0);
    step();
    chk("chg_ack",  {31'd0, cpu_ack}, 32'd1);
    chk("chg_data", cpu_rdata, 32'hDEADBEEF);
    chk("chg_mem",  mem[8'h11], 32'h44444444);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();

    // Grant counters: 5 CPU + 2 DMA after a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 5; k++) cpu_read(32'h10, 32'hDEADBEEF);
    for (int k = 0; k < 2; k++) dma_read(32'h20, 32'h12345678);
`ifdef MEM_ARB_STATS_EN
    chk("cpu_grants", {16'd0, cpu_grants}, 32'd5);
    chk("dma_grants", {16'd0, dma_grants}, 32'd2);
`else
    chk("cpu_grants", {16'd0, cpu_grants}, 32'd0);
    chk("dma_grants", {16'd0, dma_grants}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
